// File: rtl/seq_shifter_if.sv
// Handshake bundle for seq_shifter: request side, result side and busy flag.
interface seq_shifter_if #(
  parameter int WIDTH = 8
);
  localparam int SHAMT_W = $clog2(WIDTH);

  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_data;
  logic [SHAMT_W-1:0] in_shamt;
  logic [1:0]         in_mode;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_data;
  logic               busy;

  modport master (
    output in_valid, in_data, in_shamt, in_mode, out_ready,
    input  in_ready, out_valid, out_data, busy
  );

  modport slave (
    input  in_valid, in_data, in_shamt, in_mode, out_ready,
    output in_ready, out_valid, out_data, busy
  );
endinterface

// File: rtl/seq_shifter.sv
// Multi-cycle shifter: one bit per clock, LSR/LSL/ASR and optional ROR.
// Define SEQ_SHIFTER_ROTATE_EN to build ROR for mode 11 (else mode 11 = LSR).
module seq_shifter #(
  parameter int WIDTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  seq_shifter_if.slave bus
);
  localparam int SHAMT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   sreg_q, sreg_d;
  logic [WIDTH-1:0]   step;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic [1:0]         mode_q, mode_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
      mode_q  <= '0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
    end
  end

  always_comb begin
    step = {1'b0, sreg_q[WIDTH-1:1]};
    case (mode_q)
      2'b01: step = {sreg_q[WIDTH-2:0], 1'b0};
      2'b10: step = {sreg_q[WIDTH-1], sreg_q[WIDTH-1:1]};
`ifdef SEQ_SHIFTER_ROTATE_EN
      2'b11: step = {sreg_q[0], sreg_q[WIDTH-1:1]};
`endif
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          sreg_d  = bus.in_data;
          mode_d  = bus.in_mode;
          cnt_d   = bus.in_shamt;
          state_d = (bus.in_shamt == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        sreg_d = step;
        cnt_d  = cnt_q - 1'b1;
        if (cnt_q == SHAMT_W'(1)) state_d = DONE;
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Result is the shift register itself; it persists after release.
  assign bus.in_ready  = (state_q == IDLE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_data  = sreg_q;
endmodule
